// File: rtl/uno_hand_manager.sv
// UNO hand manager: holds the player's cards, moves a cursor over them, validates plays
// against the discard top and compacts the hand one slot per cycle after a card leaves it.
module uno_hand_manager #(
   parameter int          MAX_CARDS  = 108,
   parameter logic [5:0]  EMPTY_CODE = 6'h3F,
   parameter logic [5:0]  DRAW_CODE  = 6'h0F
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_play,
   input  logic        i_draw,
   input  logic [5:0]  i_draw_card,
   input  logic        i_next,
   input  logic        i_prev,
   input  logic        i_set_top,
   input  logic [5:0]  i_top_card,
   output logic [5:0]  o_hands [108:0],
   output logic [6:0]  o_hand_num,
   output logic [6:0]  o_index,
   output logic [5:0]  o_prev_card,
   output logic        o_played,
   output logic [5:0]  o_played_card,
   output logic        o_draw_req,
   output logic        o_err,
   output logic        o_busy,
   output logic        o_full
);

   localparam logic [6:0] DRAW_SLOT = 7'd108;
   localparam logic [6:0] MAX_NUM   = 7'(MAX_CARDS);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state_reg, state_next;
   logic [5:0]  slot_reg [MAX_CARDS];
   logic [6:0]  num_reg, num_next;
   logic [6:0]  index_reg, index_next;
   logic [6:0]  ptr_reg, ptr_next;
   logic [5:0]  prev_reg, prev_next;
   logic [5:0]  pcard_reg, pcard_next;
   logic        played_reg, played_next;
   logic        dreq_reg, dreq_next;
   logic        err_reg, err_next;

   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [5:0]  wr_data;
   logic [6:0]  ptr_inc;
   logic [5:0]  shift_data;
   logic [5:0]  cur_card;
   logic        legal;

   // The slot past the last card reads as empty, so the final shift step clears the tail.
   assign ptr_inc    = ptr_reg + 7'd1;
   assign shift_data = (ptr_inc < num_reg) ? slot_reg[ptr_inc] : EMPTY_CODE;
   assign cur_card   = (index_reg < num_reg) ? slot_reg[index_reg] : EMPTY_CODE;

   assign legal = (cur_card[3:0] == 4'hD) || (cur_card[3:0] == 4'hE) ||
                  (cur_card[5:4] == prev_reg[5:4]) ||
                  (cur_card[3:0] == prev_reg[3:0]) ||
                  (prev_reg[3:0] == 4'hD) || (prev_reg[3:0] == 4'hE);

   always_comb begin
      state_next  = state_reg;
      num_next    = num_reg;
      index_next  = index_reg;
      ptr_next    = ptr_reg;
      prev_next   = prev_reg;
      pcard_next  = pcard_reg;
      played_next = 1'b0;
      dreq_next   = 1'b0;
      err_next    = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = ptr_reg;
      wr_data     = shift_data;

      case (state_reg)
         IDLE: begin
            if (i_set_top) begin
               prev_next = i_top_card;
            end else if (i_play) begin
               if (index_reg == DRAW_SLOT) begin
                  dreq_next = 1'b1;
               end else if ((index_reg < num_reg) && legal) begin
                  prev_next   = cur_card;
                  pcard_next  = cur_card;
                  played_next = 1'b1;
                  ptr_next    = index_reg;
                  state_next  = SHIFT;
               end else begin
                  err_next = 1'b1;
               end
            end else if (i_draw) begin
               if (num_reg == MAX_NUM) begin
                  err_next = 1'b1;
               end else begin
                  wr_en    = 1'b1;
                  wr_addr  = num_reg;
                  wr_data  = i_draw_card;
                  num_next = num_reg + 7'd1;
               end
            end else if (i_next) begin
               if (index_reg == DRAW_SLOT)
                  index_next = (num_reg == 7'd0) ? DRAW_SLOT : 7'd0;
               else if (index_reg == num_reg - 7'd1)
                  index_next = DRAW_SLOT;
               else
                  index_next = index_reg + 7'd1;
            end else if (i_prev) begin
               if (index_reg == DRAW_SLOT)
                  index_next = (num_reg == 7'd0) ? DRAW_SLOT : num_reg - 7'd1;
               else if (index_reg == 7'd0)
                  index_next = DRAW_SLOT;
               else
                  index_next = index_reg - 7'd1;
            end
         end
         SHIFT: begin
            wr_en    = 1'b1;
            ptr_next = ptr_inc;
            if (ptr_inc >= num_reg) begin
               state_next = IDLE;
               num_next   = num_reg - 7'd1;
               // Cursor that fell off the shrunken hand snaps to the new last card.
               if (index_reg == num_reg - 7'd1)
                  index_next = (num_reg == 7'd1) ? DRAW_SLOT : num_reg - 7'd2;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg  <= IDLE;
         num_reg    <= 7'd0;
         index_reg  <= DRAW_SLOT;
         ptr_reg    <= 7'd0;
         prev_reg   <= 6'h00;
         pcard_reg  <= 6'h00;
         played_reg <= 1'b0;
         dreq_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         num_reg    <= num_next;
         index_reg  <= index_next;
         ptr_reg    <= ptr_next;
         prev_reg   <= prev_next;
         pcard_reg  <= pcard_next;
         played_reg <= played_next;
         dreq_reg   <= dreq_next;
         err_reg    <= err_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < MAX_CARDS; i++)
            slot_reg[i] <= EMPTY_CODE;
      end else if (wr_en) begin
         slot_reg[wr_addr] <= wr_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 108; gi++) begin : g_hand
         if (gi < MAX_CARDS) begin : g_used
            assign o_hands[gi] = slot_reg[gi];
         end else begin : g_unused
            assign o_hands[gi] = EMPTY_CODE;
         end
      end
   endgenerate

   assign o_hands[108]  = DRAW_CODE;
   assign o_hand_num    = num_reg;
   assign o_index       = index_reg;
   assign o_prev_card   = prev_reg;
   assign o_played      = played_reg;
   assign o_played_card = pcard_reg;
   assign o_draw_req    = dreq_reg;
   assign o_err         = err_reg;
   assign o_busy        = (state_reg == SHIFT);
   assign o_full        = (num_reg == MAX_NUM);

endmodule

// File: tb/tb_uno_hand_manager.sv
// Bench for uno_hand_manager: table of commands with expected state, plus
// hand-written sequences for a full hand, input during compaction and reset mid-shift.
module tb_uno_hand_manager;

   localparam logic [4:0] C_TOP  = 5'b10000;
   localparam logic [4:0] C_PLAY = 5'b01000;
   localparam logic [4:0] C_DRAW = 5'b00100;
   localparam logic [4:0] C_NEXT = 5'b00010;
   localparam logic [4:0] C_PREV = 5'b00001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        play = 1'b0, draw = 1'b0, nxt = 1'b0, prv = 1'b0, set_top = 1'b0;
   logic [5:0]  draw_card = 6'h00, top_card = 6'h00;
   logic [5:0]  hands [108:0];
   logic [6:0]  hand_num, index;
   logic [5:0]  prev_card, played_card;
   logic        played, draw_req, err, busy, full;

   int n_checks = 0;
   int n_fail   = 0;

   uno_hand_manager dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_play(play), .i_draw(draw), .i_draw_card(draw_card),
      .i_next(nxt), .i_prev(prv), .i_set_top(set_top), .i_top_card(top_card),
      .o_hands(hands), .o_hand_num(hand_num), .o_index(index), .o_prev_card(prev_card),
      .o_played(played), .o_played_card(played_card), .o_draw_req(draw_req), .o_err(err),
      .o_busy(busy), .o_full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  cmd;
      logic [5:0]  card;
      logic [6:0]  num;
      logic [6:0]  idx;
      logic [5:0]  prev;
      logic        played;
      logic [5:0]  pcard;
      logic        err;
      logic        dreq;
      int          busy;
      logic [23:0] slots;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(input logic [4:0] cmd, input logic [5:0] card,
                               input logic [6:0] num, input logic [6:0] idx, input logic [5:0] prev,
                               input logic pl, input logic [5:0] pc, input logic er, input logic dr,
                               input int bz, input logic [5:0] s0, input logic [5:0] s1,
                               input logic [5:0] s2, input logic [5:0] s3);
      vec_t v;
      v.cmd = cmd; v.card = card; v.num = num; v.idx = idx; v.prev = prev;
      v.played = pl; v.pcard = pc; v.err = er; v.dreq = dr; v.busy = bz;
      v.slots = {s0, s1, s2, s3};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse(input logic [4:0] cmd, input logic [5:0] card);
      @(negedge clk);
      {set_top, play, draw, nxt, prv} = cmd;
      draw_card = card;
      top_card  = card;
      @(posedge clk);
      #1;
      {set_top, play, draw, nxt, prv} = 5'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("rst num",    32'(hand_num), 32'd0);
      chk("rst idx",    32'(index), 32'd108);
      chk("rst prev",   32'(prev_card), 32'h00);
      chk("rst flags",  32'({played, err, draw_req, busy, full}), 32'd0);
      chk("rst slot0",  32'(hands[0]), 32'h3F);
      chk("rst slot107", 32'(hands[107]), 32'h3F);
      chk("rst slot108", 32'(hands[108]), 32'h0F);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply(input vec_t v, input int id);
      vec_t e;
      int nb;
      pulse(v.cmd, v.card);
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d played", id), 32'(played), 32'(e.played));
      if (e.played)
         chk($sformatf("v%0d played_card", id), 32'(played_card), 32'(e.pcard));
      chk($sformatf("v%0d err", id), 32'(err), 32'(e.err));
      chk($sformatf("v%0d draw_req", id), 32'(draw_req), 32'(e.dreq));
      nb = 0;
      while (busy === 1'b1 && nb < 300) begin
         nb++;
         @(negedge clk);
      end
      chk($sformatf("v%0d busy_cycles", id), 32'(nb), 32'(e.busy));
      @(negedge clk);
      chk($sformatf("v%0d pulses_cleared", id), 32'({played, err, draw_req}), 32'd0);
      chk($sformatf("v%0d num", id), 32'(hand_num), 32'(e.num));
      chk($sformatf("v%0d idx", id), 32'(index), 32'(e.idx));
      chk($sformatf("v%0d prev", id), 32'(prev_card), 32'(e.prev));
      chk($sformatf("v%0d full", id), 32'(full), 32'(e.num == 7'd108));
      chk($sformatf("v%0d slots", id), 32'({hands[0], hands[1], hands[2], hands[3]}), 32'(e.slots));
      chk($sformatf("v%0d draw_slot", id), 32'(hands[108]), 32'h0F);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] fill [108];
      int nb;

      //        cmd             card   num  idx  prev  pl pcard er dr bz  s0     s1     s2     s3
      vecs.push_back(mk(C_DRAW,          6'h01, 1, 108, 6'h00, 0, 6'h00, 0, 0, 0, 6'h01, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_DRAW,          6'h12, 2, 108, 6'h00, 0, 6'h00, 0, 0, 0, 6'h01, 6'h12, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_DRAW,          6'h23, 3, 108, 6'h00, 0, 6'h00, 0, 0, 0, 6'h01, 6'h12, 6'h23, 6'h3F));
      vecs.push_back(mk(C_TOP,           6'h02, 3, 108, 6'h02, 0, 6'h00, 0, 0, 0, 6'h01, 6'h12, 6'h23, 6'h3F));
      vecs.push_back(mk(C_NEXT,          6'h00, 3,   0, 6'h02, 0, 6'h00, 0, 0, 0, 6'h01, 6'h12, 6'h23, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 2,   0, 6'h01, 1, 6'h01, 0, 0, 3, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_TOP,           6'h10, 2,   0, 6'h10, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_DRAW,          6'h25, 3,   0, 6'h10, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h25, 6'h3F));
      vecs.push_back(mk(C_NEXT,          6'h00, 3,   1, 6'h10, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h25, 6'h3F));
      vecs.push_back(mk(C_NEXT,          6'h00, 3,   2, 6'h10, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h25, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 3,   2, 6'h10, 0, 6'h00, 1, 0, 0, 6'h12, 6'h23, 6'h25, 6'h3F));
      vecs.push_back(mk(C_DRAW,          6'h0D, 4,   2, 6'h10, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h25, 6'h0D));
      vecs.push_back(mk(C_NEXT,          6'h00, 4,   3, 6'h10, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h25, 6'h0D));
      vecs.push_back(mk(C_PLAY,          6'h00, 3,   2, 6'h0D, 1, 6'h0D, 0, 0, 1, 6'h12, 6'h23, 6'h25, 6'h3F));
      vecs.push_back(mk(C_PLAY | C_DRAW, 6'h30, 2,   1, 6'h25, 1, 6'h25, 0, 0, 1, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PREV,          6'h00, 2,   0, 6'h25, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PREV,          6'h00, 2, 108, 6'h25, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 2, 108, 6'h25, 0, 6'h00, 0, 1, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PREV,          6'h00, 2,   1, 6'h25, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_NEXT,          6'h00, 2, 108, 6'h25, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_NEXT,          6'h00, 2,   0, 6'h25, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 2,   0, 6'h25, 0, 6'h00, 1, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_TOP,           6'h11, 2,   0, 6'h11, 0, 6'h00, 0, 0, 0, 6'h12, 6'h23, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 1,   0, 6'h12, 1, 6'h12, 0, 0, 2, 6'h23, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 1,   0, 6'h12, 0, 6'h00, 1, 0, 0, 6'h23, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_TOP,           6'h33, 1,   0, 6'h33, 0, 6'h00, 0, 0, 0, 6'h23, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 0, 108, 6'h23, 1, 6'h23, 0, 0, 1, 6'h3F, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_NEXT,          6'h00, 0, 108, 6'h23, 0, 6'h00, 0, 0, 0, 6'h3F, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PREV,          6'h00, 0, 108, 6'h23, 0, 6'h00, 0, 0, 0, 6'h3F, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_TOP | C_DRAW,  6'h05, 0, 108, 6'h05, 0, 6'h00, 0, 0, 0, 6'h3F, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_DRAW | C_NEXT, 6'h2E, 1, 108, 6'h05, 0, 6'h00, 0, 0, 0, 6'h2E, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_NEXT | C_PREV, 6'h00, 1,   0, 6'h05, 0, 6'h00, 0, 0, 0, 6'h2E, 6'h3F, 6'h3F, 6'h3F));
      vecs.push_back(mk(C_PLAY,          6'h00, 0, 108, 6'h2E, 1, 6'h2E, 0, 0, 1, 6'h3F, 6'h3F, 6'h3F, 6'h3F));

      do_reset();
      foreach (vecs[i]) begin
         apply(vecs[i], i);
         $display("vector %0d cmd=%05b num=%0d idx=%0d prev=%02h", i, vecs[i].cmd, hand_num, index, prev_card);
      end

      // Fill the hand completely, then overflow it by one.
      do_reset();
      for (int i = 0; i < 108; i++) begin
         fill[i] = 6'($urandom_range(0, 62));
         pulse(C_DRAW, fill[i]);
      end
      @(negedge clk);
      chk("full num", 32'(hand_num), 32'd108);
      chk("full flag", 32'(full), 32'd1);
      for (int i = 0; i < 108; i++)
         chk($sformatf("full slot%0d", i), 32'(hands[i]), 32'(fill[i]));
      pulse(C_DRAW, 6'h01);
      @(negedge clk);
      chk("overflow err", 32'(err), 32'd1);
      chk("overflow num", 32'(hand_num), 32'd108);
      @(negedge clk);
      chk("overflow err width", 32'(err), 32'd0);
      chk("overflow slot107", 32'(hands[107]), 32'(fill[107]));
      $display("full hand: num=%0d full=%0b", hand_num, full);

      // A cursor move issued during compaction is dropped.
      do_reset();
      pulse(C_DRAW, 6'h01);
      pulse(C_DRAW, 6'h02);
      pulse(C_DRAW, 6'h03);
      pulse(C_TOP, 6'h00);
      pulse(C_NEXT, 6'h00);
      pulse(C_PLAY, 6'h00);
      @(negedge clk);
      chk("busy during shift", 32'(busy), 32'd1);
      nxt = 1'b1;
      @(posedge clk);
      #1;
      nxt = 1'b0;
      nb = 0;
      while (busy === 1'b1 && nb < 300) begin
         nb++;
         @(negedge clk);
      end
      chk("busy bound", 32'(nb < 300), 32'd1);
      chk("next dropped idx", 32'(index), 32'd0);
      chk("next dropped num", 32'(hand_num), 32'd2);
      chk("next dropped slots", 32'({hands[0], hands[1], hands[2]}), 32'({6'h02, 6'h03, 6'h3F}));
      $display("next during busy: idx=%0d num=%0d", index, hand_num);

      // Reset asserted in the second shift cycle aborts compaction immediately.
      pulse(C_PLAY, 6'h00);
      @(negedge clk);
      chk("shift cycle1 busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("shift cycle2 busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort num", 32'(hand_num), 32'd0);
      chk("abort idx", 32'(index), 32'd108);
      chk("abort slots", 32'({hands[0], hands[1], hands[2]}), 32'({6'h3F, 6'h3F, 6'h3F}));
      chk("abort prev", 32'(prev_card), 32'h00);
      $display("reset mid-shift: busy=%0b num=%0d", busy, hand_num);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post abort busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uno_hand_manager.md
UNO_HAND_MANAGER -- requirements
Module: uno_hand_manager

Interface
REQ-001 SHALL have parameter MAX_CARDS, default 108, meaning the maximum number of cards held in hand slots 0..MAX_CARDS-1.
REQ-002 SHALL have parameter EMPTY_CODE, default 6'h3F, meaning the code of an unused slot.
REQ-003 SHALL have parameter DRAW_CODE, default 6'h0F, meaning the constant code presented in draw slot 108.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock of the block.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_play, input, 1 bit: one-cycle pulse requesting to play the card at the cursor.
REQ-007 SHALL have port i_draw, input, 1 bit: one-cycle pulse requesting to append i_draw_card.
REQ-008 SHALL have port i_draw_card, input, 6 bits: card code to append; bits [5:4] are colour and bits [3:0] are value.
REQ-009 SHALL have port i_next, input, 1 bit: one-cycle pulse to move the cursor forward.
REQ-010 SHALL have port i_prev, input, 1 bit: one-cycle pulse to move the cursor backward.
REQ-011 SHALL have port i_set_top, input, 1 bit: one-cycle pulse to load i_top_card as the discard top.
REQ-012 SHALL have port i_top_card, input, 6 bits: starting discard card.
REQ-013 SHALL have port o_hands, output, array [108:0] of 6 bits: hand slot contents for the VGA display.
REQ-014 SHALL have port o_hand_num, output, 7 bits: number of cards held.
REQ-015 SHALL have port o_index, output, 7 bits: cursor position, 0..o_hand_num-1 or 108 (draw slot).
REQ-016 SHALL have port o_prev_card, output, 6 bits: current discard top.
REQ-017 SHALL have port o_played, output, 1 bit: one-cycle pulse when a card is accepted; o_played_card (6 bits) is valid in the same cycle.
REQ-018 SHALL have port o_draw_req, output, 1 bit: one-cycle pulse when play is requested with the cursor on slot 108.
REQ-019 SHALL have port o_err, output, 1 bit: one-cycle pulse on an illegal play or on a draw while full.
REQ-020 SHALL have ports o_busy and o_full, outputs, 1 bit each: o_busy means compaction is in progress; o_full means o_hand_num == MAX_CARDS.

Function
REQ-021 o_hands[108] SHALL always equal DRAW_CODE; slots at or above o_hand_num (except 108) SHALL hold EMPTY_CODE.
REQ-022 FSM states SHALL be IDLE and SHIFT; commands SHALL be sampled only in IDLE; all inputs SHALL be ignored (dropped, not queued) while o_busy is high.
REQ-023 In IDLE, at most one command SHALL execute per cycle, with priority i_set_top > i_play > i_draw > i_next > i_prev; lower-priority pulses in the same cycle SHALL be dropped.
REQ-024 i_set_top SHALL load o_prev_card from i_top_card on the next edge.
REQ-025 i_draw with o_hand_num < MAX_CARDS SHALL write slot[o_hand_num] = i_draw_card and increment o_hand_num; o_index SHALL be unchanged.
REQ-026 i_draw while o_full SHALL pulse o_err and leave all state unchanged.
REQ-027 A play SHALL be legal if the card value is 4'hD or 4'hE (wild), or its colour equals o_prev_card[5:4], or its value equals o_prev_card[3:0], or o_prev_card[3:0] is 4'hD or 4'hE.
REQ-028 A legal play at index k < o_hand_num SHALL, on the next edge, set o_prev_card = card, pulse o_played with o_played_card = card, raise o_busy, and enter SHIFT with pointer p = k.
REQ-029 In SHIFT, while p < o_hand_num-1, each cycle SHALL set slot[p] = slot[p+1] and p = p+1.
REQ-030 When p == o_hand_num-1, SHIFT SHALL set slot[p] = EMPTY_CODE, decrement o_hand_num, and return to IDLE; o_busy SHALL be high for exactly (o_hand_num - k) cycles.
REQ-031 On leaving SHIFT, if o_index equals the new o_hand_num, o_index SHALL become new o_hand_num-1, or 108 if the hand is now empty; otherwise o_index SHALL be unchanged.
REQ-032 An illegal play SHALL pulse o_err with no other state change; a play at o_index == 108 SHALL pulse o_draw_req only.
REQ-033 i_next SHALL move o_index 108->0 (stay at 108 if the hand is empty), o_hand_num-1 -> 108, otherwise +1.
REQ-034 i_prev SHALL move o_index 108 -> o_hand_num-1 (stay at 108 if the hand is empty), 0 -> 108, otherwise -1.
REQ-035 All output pulses SHALL be registered and exactly one i_clk cycle wide.

Reset
REQ-036 While i_rst_n is low, the block SHALL asynchronously clear slots 0..107 to EMPTY_CODE and set o_hand_num=0, o_index=108, o_prev_card=6'h00, and all pulses, o_busy and o_full to 0, with the FSM in IDLE.
REQ-037 A reset asserted during SHIFT SHALL abort compaction with no partial state retained.

Verification
REQ-038 Reset, then three draws 6'h01, 6'h12, 6'h23 -> o_hand_num=3, slots 0..2 = 01,12,23, slot 3 = 3F, slot 108 = 0F, o_index=108.
REQ-039 From REQ-038, top card 6'h02, i_next once (o_index=0), play -> o_played with card 6'h01, o_busy for 3 cycles, then slots = 12,23,3F, o_hand_num=2, o_prev_card=01.
REQ-040 Top card 6'h10, cursor on card 6'h25 -> play gives an o_err pulse and unchanged state; cursor on card 6'h0D -> play is accepted.
REQ-041 Draw 108 cards -> o_full=1; a 109th draw -> o_err pulse, o_hand_num stays 108.
REQ-042 i_play and i_draw in the same cycle -> only the play executes; i_next during o_busy -> o_index unchanged after SHIFT.
REQ-043 Reset asserted in the second SHIFT cycle -> all slots 3F, o_hand_num=0, o_busy=0 immediately.
